// File: rtl/step_pulse_receiver.sv
// -----------------------------------------------------------------------------
// step_pulse_receiver
//
// Receive end of the single-pulse STEP interface. STEP_IN is an asynchronous
// active-high level from an external pulse generator. It is synchronised, and
// each high pulse is measured in CLK cycles. The pulse is then reported as one
// of three results:
//   - valid   : width in MIN_WIDTH..MAX_WIDTH; WIDTH updated, VALID strobed
//   - glitch  : shorter than MIN_WIDTH; GLITCH strobed, nothing else changes
//   - timeout : still high after MAX_WIDTH cycles; TIMEOUT strobed, the rest
//               of that pulse (including its fall) is ignored
//
// Ports:
//   CLK        in   system clock
//   RSTn       in   asynchronous active-low reset
//   STEP_IN    in   asynchronous pulse input, active high
//   WIDTH      out  width of last valid pulse (held)
//   VALID      out  one-cycle strobe, WIDTH just updated
//   GLITCH     out  one-cycle strobe, short pulse discarded
//   TIMEOUT    out  one-cycle strobe, pulse reached MAX_WIDTH still high
//   BUSY       out  high whenever the receiver is not idle
//   PULSE_CNT  out  count of valid pulses, wraps at 2^16
// -----------------------------------------------------------------------------
module step_pulse_receiver #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 32,
    parameter int MIN_WIDTH   = 2,
    parameter int MAX_WIDTH   = 50000001
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             STEP_IN,
    output logic [CNT_W-1:0] WIDTH,
    output logic             VALID,
    output logic             GLITCH,
    output logic             TIMEOUT,
    output logic             BUSY,
    output logic [15:0]      PULSE_CNT
);

    localparam logic [CNT_W-1:0] MIN_W = CNT_W'(MIN_WIDTH);
    localparam logic [CNT_W-1:0] MAX_W = CNT_W'(MAX_WIDTH);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_MEASURE = 2'd1,
        S_STUCK   = 2'd2
    } state_t;

    // Synchroniser and edge-detect flops reset to 1. A pulse that is already
    // high when reset is released therefore never produces a rise. This
    // avoids reporting a partial measurement.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   step_dly_q;
    logic                   step_s;
    logic                   rise;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            sync_q     <= '1;
            step_dly_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], STEP_IN};
            step_dly_q <= step_s;
        end
    end

    assign step_s = sync_q[SYNC_STAGES-1];
    assign rise   = step_s & ~step_dly_q;

    // FSM and measurement state.
    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [CNT_W-1:0] width_q,   width_d;
    logic [15:0]      pcnt_q,    pcnt_d;
    logic             valid_q,   valid_d;
    logic             glitch_q,  glitch_d;
    logic             timeout_q, timeout_d;
    logic             busy_q,    busy_d;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            width_q   <= '0;
            pcnt_q    <= '0;
            valid_q   <= 1'b0;
            glitch_q  <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            width_q   <= width_d;
            pcnt_q    <= pcnt_d;
            valid_q   <= valid_d;
            glitch_q  <= glitch_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        width_d   = width_q;
        pcnt_d    = pcnt_q;
        valid_d   = 1'b0;
        glitch_d  = 1'b0;
        timeout_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rise) begin
                    // The rise cycle itself is the first high cycle of the pulse.
                    state_d = S_MEASURE;
                    cnt_d   = ONE;
                end else begin
                    cnt_d   = '0;
                end
            end

            S_MEASURE: begin
                if (step_s) begin
                    if (cnt_q == MAX_W) begin
                        // A pulse of exactly MAX_WIDTH is still accepted if it
                        // falls next cycle. Reaching this branch means it did not.
                        timeout_d = 1'b1;
                        state_d   = S_STUCK;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end else begin
                    if (cnt_q < MIN_W) begin
                        glitch_d = 1'b1;
                    end else begin
                        width_d = cnt_q;
                        valid_d = 1'b1;
                        pcnt_d  = pcnt_q + 16'd1;
                    end
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end

            S_STUCK: begin
                if (!step_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Registered from the next state so that BUSY lines up with the state.
        busy_d = (state_d != S_IDLE);
    end

    assign WIDTH     = width_q;
    assign VALID     = valid_q;
    assign GLITCH    = glitch_q;
    assign TIMEOUT   = timeout_q;
    assign BUSY      = busy_q;
    assign PULSE_CNT = pcnt_q;

endmodule

// File: tb/tb_step_pulse_receiver.sv
module tb_step_pulse_receiver;

    localparam int SYNC = 2;
    localparam int CW   = 32;
    localparam int MINW = 2;
    localparam int MAXW = 10;

    logic          CLK = 1'b0;
    logic          RSTn = 1'b0;
    logic          STEP_IN = 1'b0;
    logic [CW-1:0] WIDTH;
    logic          VALID, GLITCH, TIMEOUT, BUSY;
    logic [15:0]   PULSE_CNT;

    step_pulse_receiver #(
        .SYNC_STAGES(SYNC),
        .CNT_W      (CW),
        .MIN_WIDTH  (MINW),
        .MAX_WIDTH  (MAXW)
    ) dut (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .STEP_IN  (STEP_IN),
        .WIDTH    (WIDTH),
        .VALID    (VALID),
        .GLITCH   (GLITCH),
        .TIMEOUT  (TIMEOUT),
        .BUSY     (BUSY),
        .PULSE_CNT(PULSE_CNT)
    );

    always #10 CLK = ~CLK;

    // Edge counter: at a negedge, cyc is the index of the posedge just passed.
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // kind: 0 = valid, 1 = glitch, 2 = timeout
    typedef struct {
        int          kind;
        int          at;
        logic [31:0] width;
        logic [15:0] pcnt;
        logic        busy;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_width = '0;
    logic [15:0] m_pcnt  = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Reference model: classify a pulse of w sampled-high cycles and predict
    // the strobe, its cycle, and the register contents when it appears.
    task automatic send(input int w, input int gap);
        exp_t e;
        int   first;
        @(negedge CLK);
        STEP_IN = 1'b1;
        first = cyc + 1;
        if (w < MINW) begin
            e.kind = 1; e.at = first + SYNC + w; e.busy = 1'b0;
        end else if (w <= MAXW) begin
            m_width = w;
            m_pcnt  = m_pcnt + 16'd1;
            e.kind = 0; e.at = first + SYNC + w; e.busy = 1'b0;
        end else begin
            e.kind = 2; e.at = first + SYNC + MAXW; e.busy = 1'b1;
        end
        e.width = m_width;
        e.pcnt  = m_pcnt;
        sbq.push_back(e);
        $display("pulse w=%0d gap=%0d kind=%0d due=%0d", w, gap, e.kind, e.at);
        repeat (w) @(negedge CLK);
        STEP_IN = 1'b0;
        repeat (gap - 1) @(negedge CLK);
    endtask

    task automatic drain();
        int n = 0;
        while (sbq.size() > 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (sbq.size() > 0) fail("drain_timeout");
        repeat (4) @(negedge CLK);
    endtask

    // Monitor: pops the scoreboard whenever a strobe appears.
    exp_t mon_e;
    int   mon_stb;
    int   mon_kind;
    always @(negedge CLK) begin
        if (RSTn) begin
            while (sbq.size() > 0 && sbq[0].at < cyc) begin
                fail($sformatf("missed_strobe kind=%0d due=%0d", sbq[0].kind, sbq[0].at));
                void'(sbq.pop_front());
            end
            mon_stb = int'(VALID) + int'(GLITCH) + int'(TIMEOUT);
            if (mon_stb > 1) fail("strobes_not_exclusive");
            if (mon_stb != 0) begin
                mon_kind = VALID ? 0 : (GLITCH ? 1 : 2);
                if (sbq.size() == 0) begin
                    fail($sformatf("unexpected_strobe kind=%0d", mon_kind));
                end else begin
                    mon_e = sbq.pop_front();
                    chk("strobe_kind", mon_kind, mon_e.kind);
                    chk("strobe_cycle", cyc, mon_e.at);
                    chk("width", WIDTH, mon_e.width);
                    chk("pulse_cnt", PULSE_CNT, mon_e.pcnt);
                    chk("busy_at_strobe", BUSY, mon_e.busy);
                    $display("strobe kind=%0d cyc=%0d width=%0d pcnt=%0d", mon_kind, cyc, WIDTH, PULSE_CNT);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        RSTn = 1'b0;
        STEP_IN = 1'b0;
        repeat (3) @(negedge CLK);
        chk("rst_width", WIDTH, 0);
        chk("rst_pcnt", PULSE_CNT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_strobes", {VALID, GLITCH, TIMEOUT}, 0);
        RSTn = 1'b1;
        repeat (3) @(negedge CLK);

        // Directed: nominal, glitch, boundary MAX, timeout, back-to-back.
        send(6, 3);
        send(1, 3);
        send(MAXW, 2);
        send(MAXW + 5, 1);
        send(MAXW + 1, 1);
        send(3, 1);
        send(4, 1);
        send(MINW, 1);
        drain();
        chk("idle_busy", BUSY, 0);

        // Reset in the middle of a pulse, released with STEP_IN still high.
        STEP_IN = 1'b1;
        repeat (4) @(negedge CLK);
        chk("busy_mid_pulse", BUSY, 1);
        #3 RSTn = 1'b0;
        #1;
        chk("midrst_width", WIDTH, 0);
        chk("midrst_pcnt", PULSE_CNT, 0);
        chk("midrst_busy", BUSY, 0);
        chk("midrst_strobes", {VALID, GLITCH, TIMEOUT}, 0);
        sbq.delete();
        m_width = '0;
        m_pcnt  = '0;
        @(negedge CLK);
        RSTn = 1'b1;
        repeat (6) @(negedge CLK);
        chk("post_rst_busy", BUSY, 0);
        STEP_IN = 1'b0;
        repeat (4) @(negedge CLK);
        send(5, 2);
        drain();

        // Randomised pulse train.
        for (int i = 0; i < 300; i++) begin
            send(int'($urandom_range(1, MAXW + 4)), int'($urandom_range(1, 4)));
        end
        drain();
        chk("final_queue_empty", sbq.size(), 0);
        chk("final_pcnt", PULSE_CNT, m_pcnt);
        chk("final_width", WIDTH, m_width);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
